// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle CPU control FSM with memory handshakes, wait timeout and sticky fault; define CTRL_ILLEGAL_EN to fault on undecoded instructions
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       rs_wr,
  output logic       rt_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic       alu_src,
  output logic [2:0] alu_ctrl,
  output logic [1:0] mem_to_reg,
  output logic       jump,
  output logic       beq,
  output logic       bne,
  output logic [2:0] state,
  output logic       fault,
  output logic [1:0] fault_cause
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_FAULT = 3'd5} st_t;
`ifdef CTRL_ILLEGAL_EN
  localparam bit ILL_FAULT = 1'b1;
`else
  localparam bit ILL_FAULT = 1'b0;
`endif
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
  st_t st, nxt, d_nxt;
  logic [TO_W-1:0] cnt;
  logic [1:0] rd_q, m2r_q, d_rd, d_m2r;
  logic [2:0] alu_q, d_alu;
  logic src_q, j_q, beq_q, bne_q, st_q;
  logic d_legal, d_src, d_j, d_beq, d_bne, d_st, to, waiting, show;
  always_comb begin
    d_legal = 1'b1;
    d_rd = 2'd0;
    d_src = 1'b0;
    d_alu = 3'd0;
    d_m2r = 2'd0;
    d_j = 1'b0;
    d_beq = 1'b0;
    d_bne = 1'b0;
    d_st = 1'b0;
    d_nxt = S_EX;
    case (opcode)
      6'h00: case (funct)
        6'h20: d_alu = 3'd0;
        6'h22: d_alu = 3'd1;
        6'h2a: d_alu = 3'd3;
        6'h08: begin d_j = 1'b1; d_nxt = S_IF; end
        default: d_legal = 1'b0;
      endcase
      6'h02: begin d_j = 1'b1; d_nxt = S_IF; end
      6'h03: begin d_j = 1'b1; d_rd = 2'd1; d_m2r = 2'd2; d_nxt = S_WB; end
      6'h04: begin d_beq = 1'b1; d_alu = 3'd1; end
      6'h05: begin d_bne = 1'b1; d_alu = 3'd1; end
      6'h08: begin d_rd = 2'd2; d_src = 1'b1; end
      6'h0e: begin d_rd = 2'd2; d_src = 1'b1; d_alu = 3'd2; end
      6'h23: begin d_rd = 2'd2; d_src = 1'b1; d_m2r = 2'd1; end
      6'h2b: begin d_src = 1'b1; d_st = 1'b1; end
      default: d_legal = 1'b0;
    endcase
  end
  assign to = (MEM_TIMEOUT != 0) && (cnt >= TO_LIM);
  assign waiting = (st == S_IF && !imem_ready) || (st == S_MEM && !dmem_ready);
  always_comb begin
    nxt = st;
    case (st)
      S_IF:    nxt = imem_ready ? S_ID : to ? S_FAULT : S_IF;
      S_ID:    nxt = d_legal ? d_nxt : ILL_FAULT ? S_FAULT : S_IF;
      S_EX:    nxt = (beq_q || bne_q) ? S_IF : (m2r_q == 2'd1 || st_q) ? S_MEM : S_WB;
      S_MEM:   nxt = dmem_ready ? (st_q ? S_IF : S_WB) : to ? S_FAULT : S_MEM;
      S_WB:    nxt = S_IF;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IF;
      cnt <= '0;
      fault <= 1'b0;
      fault_cause <= 2'b00;
      rd_q <= 2'd0;
      src_q <= 1'b0;
      alu_q <= 3'd0;
      m2r_q <= 2'd0;
      j_q <= 1'b0;
      beq_q <= 1'b0;
      bne_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= (nxt != st) ? '0 : (waiting && cnt != '1) ? cnt + 1'b1 : cnt;
      if (nxt == S_FAULT && st != S_FAULT) begin
        fault <= 1'b1;
        fault_cause <= (st == S_IF) ? 2'b01 : (st == S_ID) ? 2'b10 : 2'b11;
      end
      if (st == S_ID && d_legal) begin
        rd_q <= d_rd;
        src_q <= d_src;
        alu_q <= d_alu;
        m2r_q <= d_m2r;
        j_q <= d_j;
        beq_q <= d_beq;
        bne_q <= d_bne;
        st_q <= d_st;
      end
    end
  end
  // fields follow the live decode during ID so jump accompanies the ID pc_wr
  assign show = (st == S_ID) && d_legal;
  assign reg_dst = show ? d_rd : rd_q;
  assign alu_src = show ? d_src : src_q;
  assign alu_ctrl = show ? d_alu : alu_q;
  assign mem_to_reg = show ? d_m2r : m2r_q;
  assign jump = show ? d_j : j_q;
  assign beq = show ? d_beq : beq_q;
  assign bne = show ? d_bne : bne_q;
  assign state = st;
  assign imem_req = rst_n && st == S_IF;
  assign ir_wr = rst_n && st == S_IF && imem_ready;
  assign pc_wr = rst_n && ((st == S_IF && imem_ready) || (show && d_j) || (st == S_EX && (beq_q || bne_q)));
  assign rs_wr = rst_n && st == S_ID;
  assign rt_wr = rst_n && st == S_ID;
  assign dmem_req = rst_n && st == S_MEM;
  assign mem_wr = rst_n && st == S_MEM && st_q;
  assign reg_wr = rst_n && st == S_WB;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven cycle vectors plus hand sequences for timeout, boundary and reset
module tb_mc_ctrl_fsm;
  logic clk = 1'b0, rst_n = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic imem_req, dmem_req, mem_wr, ir_wr, pc_wr, rs_wr, rt_wr, reg_wr, alu_src, jump, beq, bne, fault;
  logic [1:0] reg_dst, mem_to_reg, fault_cause;
  logic [2:0] alu_ctrl, state;
  logic [7:0] stb;
  logic [10:0] fld;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mc_ctrl_fsm #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .mem_wr(mem_wr), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .rs_wr(rs_wr), .rt_wr(rt_wr), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .mem_to_reg(mem_to_reg),
    .jump(jump), .beq(beq), .bne(bne), .state(state), .fault(fault), .fault_cause(fault_cause)
  );
  assign stb = {imem_req, dmem_req, mem_wr, ir_wr, pc_wr, rs_wr, rt_wr, reg_wr};
  assign fld = {reg_dst, alu_src, alu_ctrl, mem_to_reg, jump, beq, bne};
  typedef struct {
    logic rn;
    logic [5:0] op;
    logic [5:0] fn;
    logic ir;
    logic dr;
    logic [2:0] st;
    logic [7:0] sb;
    logic cf;
    logic [10:0] f;
  } vec_t;
  vec_t tv[$];
  localparam logic [7:0] Z = 8'b0000_0000, IFW = 8'b1000_0000, IFR = 8'b1001_1000;
  localparam logic [7:0] IDN = 8'b0000_0110, IDJ = 8'b0000_1110, EXB = 8'b0000_1000;
  localparam logic [7:0] MEMR = 8'b0100_0000, MEMW = 8'b0110_0000, WB = 8'b0000_0001;
  localparam logic [10:0] F_ADD = 11'b00_0_000_00_000, F_LW = 11'b10_1_000_01_000;
  localparam logic [10:0] F_JAL = 11'b01_0_000_10_100, F_BEQ = 11'b00_0_001_00_010;
  localparam logic [10:0] F_J = 11'b00_0_000_00_100, F_XORI = 11'b10_1_010_00_000;
  task automatic add(input logic rn, input logic [5:0] op, fn, input logic ir, dr,
                     input logic [2:0] st, input logic [7:0] sb, input logic cf, input logic [10:0] f);
    tv.push_back(vec_t'{rn, op, fn, ir, dr, st, sb, cf, f});
  endtask
  task automatic cyc(input logic rn, input logic [5:0] op, fn, input logic ir, dr);
    @(posedge clk);
    #1;
    rst_n = rn; opcode = op; funct = fn; imem_ready = ir; dmem_ready = dr;
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    int n;
    add(0, 6'h00, 6'h00, 1, 0, 3'd7, Z, 0, 0);
    add(0, 6'h00, 6'h00, 1, 0, 3'd0, Z, 0, 0);
    add(0, 6'h00, 6'h00, 1, 0, 3'd0, Z, 0, 0);
    add(1, 6'h00, 6'h20, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h00, 6'h20, 0, 0, 3'd1, IDN, 0, 0);
    add(1, 6'h00, 6'h20, 0, 0, 3'd2, Z, 0, 0);
    add(1, 6'h00, 6'h20, 0, 0, 3'd4, WB, 1, F_ADD);
    add(1, 6'h23, 6'h00, 0, 0, 3'd0, IFW, 0, 0);
    add(1, 6'h23, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h23, 6'h00, 0, 0, 3'd1, IDN, 0, 0);
    add(1, 6'h23, 6'h00, 0, 0, 3'd2, Z, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 6'h23, 6'h00, 0, 0, 3'd3, MEMR, 0, 0);
    add(1, 6'h23, 6'h00, 0, 1, 3'd3, MEMR, 0, 0);
    add(1, 6'h23, 6'h00, 0, 0, 3'd4, WB, 1, F_LW);
    add(1, 6'h03, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h03, 6'h00, 0, 0, 3'd1, IDJ, 1, F_JAL);
    add(1, 6'h03, 6'h00, 0, 0, 3'd4, WB, 1, F_JAL);
    add(1, 6'h2b, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h2b, 6'h00, 0, 0, 3'd1, IDN, 0, 0);
    add(1, 6'h2b, 6'h00, 0, 0, 3'd2, Z, 0, 0);
    add(1, 6'h2b, 6'h00, 0, 1, 3'd3, MEMW, 0, 0);
    add(1, 6'h04, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h04, 6'h00, 0, 0, 3'd1, IDN, 0, 0);
    add(1, 6'h04, 6'h00, 0, 0, 3'd2, EXB, 1, F_BEQ);
    add(1, 6'h02, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h02, 6'h00, 0, 0, 3'd1, IDJ, 1, F_J);
    add(1, 6'h00, 6'h08, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h00, 6'h08, 0, 0, 3'd1, IDJ, 1, F_J);
    add(1, 6'h0e, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h0e, 6'h00, 0, 0, 3'd1, IDN, 0, 0);
    add(1, 6'h0e, 6'h00, 1, 1, 3'd2, Z, 0, 0);
    add(1, 6'h0e, 6'h00, 0, 0, 3'd4, WB, 1, F_XORI);
    add(1, 6'h3f, 6'h00, 1, 0, 3'd0, IFR, 0, 0);
    add(1, 6'h3f, 6'h00, 0, 0, 3'd1, IDN, 1, F_XORI);
`ifdef CTRL_ILLEGAL_EN
    add(1, 6'h3f, 6'h00, 1, 0, 3'd5, Z, 1, F_XORI);
    add(1, 6'h3f, 6'h00, 1, 0, 3'd5, Z, 1, F_XORI);
`else
    add(1, 6'h3f, 6'h00, 1, 0, 3'd0, IFR, 1, F_XORI);
    add(1, 6'h3f, 6'h00, 0, 0, 3'd1, IDN, 1, F_XORI);
`endif
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].rn, tv[i].op, tv[i].fn, tv[i].ir, tv[i].dr);
      if (tv[i].st != 3'd7) chk($sformatf("row%0d state", i), 32'(state), 32'(tv[i].st));
      chk($sformatf("row%0d strobes", i), 32'(stb), 32'(tv[i].sb));
      if (tv[i].cf) chk($sformatf("row%0d fields", i), 32'(fld), 32'(tv[i].f));
    end
`ifdef CTRL_ILLEGAL_EN
    chk("illegal fault", 32'(fault), 32'd1);
    chk("illegal cause", 32'(fault_cause), 32'd2);
`else
    chk("nop no fault", 32'(fault), 32'd0);
`endif
    // imem stuck low: five IF cycles, then sticky fault
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n = 0;
    while (state == 3'd0 && n < 20) begin
      cyc(1, 0, 0, 0, 0);
      if (state == 3'd0) n++;
    end
    chk("imem to cycles", 32'(n), 32'd5);
    chk("imem to state", 32'(state), 32'd5);
    chk("imem to fault", 32'(fault), 32'd1);
    chk("imem to cause", 32'(fault_cause), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 6'h23, 0, 1, 1);
      chk($sformatf("fault hold%0d strobes", i), 32'(stb), 32'd0);
      chk($sformatf("fault hold%0d state", i), 32'(state), 32'd5);
    end
    cyc(0, 0, 0, 1, 1);
    chk("reset strobes", 32'(stb), 32'd0);
    cyc(0, 0, 0, 1, 1);
    chk("reset state", 32'(state), 32'd0);
    chk("reset fault", 32'(fault), 32'd0);
    chk("reset cause", 32'(fault_cause), 32'd0);
    // ready on the boundary cycle wins over the timeout
    for (int i = 0; i < 4; i++) cyc(1, 0, 6'h20, 0, 0);
    cyc(1, 0, 6'h20, 1, 0);
    chk("boundary state", 32'(state), 32'd0);
    chk("boundary ir_wr", 32'(ir_wr), 32'd1);
    cyc(1, 0, 6'h20, 0, 0);
    chk("boundary next", 32'(state), 32'd1);
    chk("boundary fault", 32'(fault), 32'd0);
    // dmem stuck low during LW
    cyc(0, 0, 0, 0, 0);
    cyc(1, 6'h23, 0, 1, 0);
    cyc(1, 6'h23, 0, 0, 0);
    cyc(1, 6'h23, 0, 0, 0);
    chk("lw ex", 32'(state), 32'd2);
    n = 0;
    cyc(1, 6'h23, 0, 0, 0);
    while (state == 3'd3 && n < 20) begin
      n++;
      cyc(1, 6'h23, 0, 0, 0);
    end
    chk("dmem to cycles", 32'(n), 32'd5);
    chk("dmem to state", 32'(state), 32'd5);
    chk("dmem to cause", 32'(fault_cause), 32'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
